// File: rtl/execute_alu_ccr.sv
// ============================================================================
// execute_alu_ccr
//
// Execute-stage ALU with a condition-code register (CCR = {C,N,Z}).
// Takes the decoded ALU op and operands from ID/EX and registers the result
// into the EX/MEM boundary with one cycle of latency. A one-deep CCR shadow
// is saved on interrupt entry and restored on RTI. The live flags are exported
// so the branch unit can resolve JZ/JN/JC.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     ID/EX holds a live instruction
//   alu_ctrl     ALU opcode (13-15 behave as PASSA)
//   op_a, op_b   operands; shift amount is op_b[4:0]
//   stall        freeze every register this cycle
//   flush        kill the instruction currently at the input
//   int_save     copy the (this-cycle updated) CCR into the shadow
//   rti_restore  load the CCR from the shadow
//   out_valid    result register holds a live instruction
//   result       registered ALU result
//   ccr          registered flags {C,N,Z}
// ============================================================================
module execute_alu_ccr #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              stall,
    input  logic              flush,
    input  logic              int_save,
    input  logic              rti_restore,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        ccr
);

    localparam logic [CTRL_W-1:0] OP_PASSB = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_NOT   = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_INC   = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_DEC   = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] OP_SHL   = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] OP_SHR   = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] OP_SETC  = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] OP_CLRC  = CTRL_W'(12);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        ccr_q, ccr_d;
    logic [2:0]        shadow_q, shadow_d;

    logic              accept;
    logic [4:0]        shamt;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   shl_w;
    logic [DATA_W:0]   shr_w;
    logic [DATA_W-1:0] alu_res;
    logic              c_new;
    logic              zn_upd;
    logic [2:0]        ccr_op;

    assign accept = in_valid & ~flush & ~stall;
    assign shamt  = op_b[4:0];

    // Shifts run one bit wider than the data so the last bit shifted out
    // lands in the extra position; amounts past DATA_W naturally give zero.
    assign shl_w = {1'b0, op_a} << shamt;
    assign shr_w = {op_a, 1'b0} >> shamt;

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        alu_res = op_a;
        c_new   = ccr_q[2];
        zn_upd  = 1'b0;
        sum_w   = '0;
        case (alu_ctrl)
            OP_PASSB: begin alu_res = op_b;  zn_upd = 1'b1; end
            OP_NOT:   begin alu_res = ~op_a; zn_upd = 1'b1; end
            OP_AND:   begin alu_res = op_a & op_b; zn_upd = 1'b1; end
            OP_OR:    begin alu_res = op_a | op_b; zn_upd = 1'b1; end
            OP_INC: begin
                sum_w   = {1'b0, op_a} + (DATA_W+1)'(1);
                alu_res = sum_w[DATA_W-1:0];
                c_new   = sum_w[DATA_W];
                zn_upd  = 1'b1;
            end
            OP_DEC: begin
                // Top bit of the widened difference is the borrow.
                sum_w   = {1'b0, op_a} - (DATA_W+1)'(1);
                alu_res = sum_w[DATA_W-1:0];
                c_new   = sum_w[DATA_W];
                zn_upd  = 1'b1;
            end
            OP_ADD: begin
                sum_w   = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum_w[DATA_W-1:0];
                c_new   = sum_w[DATA_W];
                zn_upd  = 1'b1;
            end
            OP_SUB: begin
                sum_w   = {1'b0, op_a} - {1'b0, op_b};
                alu_res = sum_w[DATA_W-1:0];
                c_new   = sum_w[DATA_W];
                zn_upd  = 1'b1;
            end
            OP_SHL: begin
                alu_res = shl_w[DATA_W-1:0];
                zn_upd  = 1'b1;
                if (shamt != 5'd0) c_new = shl_w[DATA_W];
            end
            OP_SHR: begin
                alu_res = shr_w[DATA_W:1];
                zn_upd  = 1'b1;
                if (shamt != 5'd0) c_new = shr_w[0];
            end
            OP_SETC: c_new = 1'b1;
            OP_CLRC: c_new = 1'b0;
            default: ;  // PASSA and 13-15: pass op_a, flags untouched
        endcase
    end

    always_comb begin
        // Flags as they stand after this cycle's op, before any RTI override;
        // this is also what an interrupt save captures.
        ccr_op = ccr_q;
        if (accept) begin
            ccr_op[2] = c_new;
            if (zn_upd) ccr_op[1:0] = {alu_res[DATA_W-1], (alu_res == '0)};
        end
        ccr_d       = rti_restore ? shadow_q : ccr_op;
        // A simultaneous restore keeps the old shadow.
        shadow_d    = (int_save & ~rti_restore) ? ccr_op : shadow_q;
        result_d    = accept ? alu_res : result_q;
        out_valid_d = accept;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ccr_q       <= 3'b000;
            shadow_q    <= 3'b000;
        end else if (!stall) begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ccr_q       <= ccr_d;
            shadow_q    <= shadow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ccr       = ccr_q;

endmodule

// File: tb/tb_execute_alu_ccr.sv
module tb_execute_alu_ccr;

    localparam logic [3:0] OP_PASSA = 4'd0;
    localparam logic [3:0] OP_PASSB = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_SETC  = 4'd11;
    localparam logic [3:0] OP_CLRC  = 4'd12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        int_save = 1'b0;
    logic        rti_restore = 1'b0;
    logic        out_valid;
    logic [15:0] result;
    logic [2:0]  ccr;

    int checks = 0;
    int errors = 0;

    execute_alu_ccr #(.DATA_W(16), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
        .op_a(op_a), .op_b(op_b), .stall(stall), .flush(flush),
        .int_save(int_save), .rti_restore(rti_restore),
        .out_valid(out_valid), .result(result), .ccr(ccr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int unsigned res;
        bit          c;
        bit          sets_zn;
    } alu_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] res;
        logic [2:0]  ccr;     // {C,N,Z}
        logic [2:0]  shadow;
    } mstate_t;

    mstate_t m = '0;

    function automatic alu_t alu_model(int unsigned ctrl, int unsigned a, int unsigned b, bit c_in);
        alu_t r;
        int unsigned s;
        r.res = a;
        r.c = c_in;
        r.sets_zn = 1'b1;
        s = b % 32;
        case (ctrl)
            1:  r.res = b;
            2:  r.res = 65535 - a;
            3:  begin r.res = (a + 1) % 65536; r.c = (a == 65535); end
            4:  begin r.res = (a + 65535) % 65536; r.c = (a == 0); end
            5:  begin r.res = (a + b) % 65536; r.c = ((a + b) > 65535); end
            6:  begin r.res = (a + 65536 - b) % 65536; r.c = (a < b); end
            7:  r.res = a & b;
            8:  r.res = a | b;
            9: begin
                if (s == 0) r.res = a;
                else if (s < 16) begin
                    r.res = (a * (1 << s)) % 65536;
                    r.c = ((a >> (16 - s)) & 1) != 0;
                end else if (s == 16) begin r.res = 0; r.c = (a & 1) != 0; end
                else begin r.res = 0; r.c = 1'b0; end
            end
            10: begin
                if (s == 0) r.res = a;
                else if (s < 16) begin
                    r.res = a / (1 << s);
                    r.c = ((a >> (s - 1)) & 1) != 0;
                end else if (s == 16) begin r.res = 0; r.c = (a >= 32768); end
                else begin r.res = 0; r.c = 1'b0; end
            end
            11: begin r.c = 1'b1; r.sets_zn = 1'b0; end
            12: begin r.c = 1'b0; r.sets_zn = 1'b0; end
            default: r.sets_zn = 1'b0;
        endcase
        return r;
    endfunction

    function automatic mstate_t model_next(mstate_t cur);
        mstate_t nx;
        alu_t r;
        logic [2:0] flags;
        nx = cur;
        if (stall) return cur;
        r = alu_model(32'(alu_ctrl), 32'(op_a), 32'(op_b), cur.ccr[2]);
        flags = cur.ccr;
        nx.valid = in_valid && !flush;
        if (nx.valid) begin
            nx.res = r.res[15:0];
            flags[2] = r.c;
            if (r.sets_zn) begin
                flags[1] = (r.res >= 32768);
                flags[0] = (r.res == 0);
            end
        end
        nx.ccr = rti_restore ? cur.shadow : flags;
        if (int_save && !rti_restore) nx.shadow = flags;
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m);
    end

    // Outputs are compared against the model on every falling edge.
    always @(negedge clk) begin
        check("model_out_valid", 32'(out_valid), 32'(m.valid));
        check("model_result",    32'(result),    32'(m.res));
        check("model_ccr",       32'(ccr),       32'(m.ccr));
    end

    // ---------------- stimulus ----------------
    // Drive inputs at a falling edge, then let one full cycle elapse.
    task automatic issue(input logic v, input logic [3:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic st, input logic fl,
                         input logic sv, input logic rt);
        in_valid = v; alu_ctrl = c; op_a = a; op_b = b;
        stall = st; flush = fl; int_save = sv; rti_restore = rt;
        @(negedge clk);
    endtask

    task automatic op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        issue(1'b1, c, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [15:0] r, input logic [2:0] f);
        check({name, "_valid"},  32'(out_valid), 32'(v));
        check({name, "_result"}, 32'(result),    32'(r));
        check({name, "_ccr"},    32'(ccr),       32'(f));
    endtask

    task automatic random_cycles(input int n);
        logic [15:0] a, b;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: a = 16'hFFFF;
                1: a = 16'h0000;
                2: a = 16'h8000;
                default: a = 16'($urandom);
            endcase
            b = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            issue($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), a, b,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        expect_out("reset", 1'b0, 16'h0000, 3'b000);
        rst_n = 1'b1;

        op(OP_ADD, 16'hFFFF, 16'h0001);
        expect_out("add_carry", 1'b1, 16'h0000, 3'b101);
        op(OP_SUB, 16'h0003, 16'h0005);
        expect_out("sub_borrow", 1'b1, 16'hFFFE, 3'b110);
        op(OP_AND, 16'h0000, 16'h0000);
        expect_out("and_keep_c", 1'b1, 16'h0000, 3'b101);
        op(OP_SHL, 16'h8001, 16'd1);
        expect_out("shl_1", 1'b1, 16'h0002, 3'b100);
        op(OP_SHR, 16'h0001, 16'd16);
        expect_out("shr_16", 1'b1, 16'h0000, 3'b001);
        op(OP_SHL, 16'h1234, 16'd0);
        expect_out("shl_0", 1'b1, 16'h1234, 3'b000);
        op(OP_PASSB, 16'h0000, 16'h8000);
        expect_out("passb", 1'b1, 16'h8000, 3'b010);
        op(OP_SETC, 16'h5555, 16'h0000);
        expect_out("setc", 1'b1, 16'h5555, 3'b110);
        op(OP_CLRC, 16'hAAAA, 16'h0000);
        expect_out("clrc", 1'b1, 16'hAAAA, 3'b010);

        issue(1'b1, OP_ADD, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("stall1", 1'b1, 16'hAAAA, 3'b010);
        issue(1'b1, OP_ADD, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_out("stall2", 1'b1, 16'hAAAA, 3'b010);
        issue(1'b1, OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("flush", 1'b0, 16'hAAAA, 3'b010);

        op(OP_ADD, 16'hFFFF, 16'h0001);
        expect_out("pre_save", 1'b1, 16'h0000, 3'b101);
        issue(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("save_add", 1'b1, 16'h8000, 3'b010);
        op(OP_ADD, 16'hFFFF, 16'h0002);
        expect_out("between", 1'b1, 16'h0001, 3'b100);
        issue(1'b1, OP_SUB, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("restore_sub", 1'b1, 16'h0002, 3'b010);
        op(OP_PASSA, 16'h4321, 16'h0000);
        expect_out("passa", 1'b1, 16'h4321, 3'b010);

        random_cycles(1500);

        // Asynchronous reset in the middle of a live cycle.
        issue(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1 expect_out("async_reset", 1'b0, 16'h0000, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(OP_ADD, 16'hFFFF, 16'h0001);
        expect_out("first_after_reset", 1'b1, 16'h0000, 3'b101);
        issue(1'b0, OP_PASSA, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("shadow_cleared", 1'b0, 16'h0000, 3'b000);

        random_cycles(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
